// File: rtl/loader_pkg.sv
// loader_pkg: shared states, word geometry and sizing helper for the program loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_LEN, RECV, WRITE, CHECK, RUN, ERROR} state_t;
  localparam int WORD_W = 32;
  localparam int BYTES_PER_WORD = 4;
  function automatic int words(input int addr_w);
    return 2 ** (addr_w - 2);
  endfunction
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input plus instruction/data memory write ports of the loader.
interface program_loader_if #(
  parameter int IMEM_ADDR_W = 8,
  parameter int DMEM_ADDR_W = 8
);
  import loader_pkg::*;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic imem_we;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic dmem_we;
  logic [DMEM_ADDR_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  modport slave (
    input rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata
  );
  modport master (
    output rx_data, rx_valid,
    input rx_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/byte_packer.sv
// byte_packer: collects bytes little-endian into a word; word/word_full include the byte strobed this cycle.
module byte_packer
  import loader_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic [7:0] data,
  input  logic strobe,
  input  logic clear,
  output logic [WORD_W-1:0] word,
  output logic word_full
);
  logic [1:0] cnt;
  logic [WORD_W-1:0] acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (strobe) begin
      acc[8*cnt +: 8] <= data;
      cnt <= cnt + 2'd1;
    end
  always_comb begin
    word = acc;
    if (strobe) word[8*cnt +: 8] = data;
  end
  assign word_full = strobe && cnt == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/program_loader.sv
// program_loader: boot loader - zero-fills dmem, streams a length-prefixed image into imem, releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_ADDR_W = 8,
  parameter int DMEM_ADDR_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  program_loader_if.slave bus,
  output logic cpu_rst_n,
  output logic busy,
  output logic done,
  output logic error
);
  localparam int IMEM_WORDS = words(IMEM_ADDR_W);
  localparam logic [DMEM_ADDR_W-1:0] DMEM_LAST = DMEM_ADDR_W'((words(DMEM_ADDR_W) - 1) * 4);
  state_t state;
  logic [7:0] len, idx;
  logic [WORD_W-1:0] word;
  logic word_full, take;
  assign take = bus.rx_valid && bus.rx_ready;
  assign bus.dmem_wdata = '0;
  byte_packer u_pack (
    .clk(clk),
    .rst_n(rst_n),
    .data(bus.rx_data),
    .strobe(take && state == RECV),
    .clear(state != RECV),
    .word(word),
    .word_full(word_full)
  );
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else if (take) csum <= state == WAIT_LEN ? bus.rx_data : csum ^ bus.rx_data;
`endif
  // RUN drives its outputs from inside the state, so release lags entry by one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      idx <= '0;
      bus.rx_ready <= 1'b0;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
      bus.dmem_we <= 1'b0;
      bus.dmem_addr <= '0;
      cpu_rst_n <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN, ERROR: begin
          if (state == RUN) begin
            cpu_rst_n <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
          end
          if (start) begin
            state <= CLEAR;
            cpu_rst_n <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            busy <= 1'b1;
            bus.dmem_we <= 1'b1;
            bus.dmem_addr <= '0;
          end
        end
        CLEAR:
          if (bus.dmem_addr == DMEM_LAST) begin
            bus.dmem_we <= 1'b0;
            bus.rx_ready <= 1'b1;
            state <= WAIT_LEN;
          end else bus.dmem_addr <= bus.dmem_addr + DMEM_ADDR_W'(4);
        WAIT_LEN:
          if (take) begin
            len <= bus.rx_data;
            idx <= '0;
            if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > IMEM_WORDS) begin
              state <= ERROR;
              error <= 1'b1;
              busy <= 1'b0;
              bus.rx_ready <= 1'b0;
            end else state <= RECV;
          end
        RECV:
          if (word_full) begin
            state <= WRITE;
            bus.rx_ready <= 1'b0;
            bus.imem_we <= 1'b1;
            bus.imem_addr <= IMEM_ADDR_W'({idx, 2'b00});
            bus.imem_wdata <= word;
          end
        WRITE: begin
          bus.imem_we <= 1'b0;
          idx <= idx + 8'd1;
          if (idx + 8'd1 == len) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CHECK;
            bus.rx_ready <= 1'b1;
`else
            state <= RUN;
`endif
          end else begin
            state <= RECV;
            bus.rx_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK:
          if (take) begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == csum) state <= RUN;
            else begin
              state <= ERROR;
              error <= 1'b1;
              busy <= 1'b0;
            end
          end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule
